// File: rtl/rfic_seq_pkg.sv
// Shared definitions for the RFIC multi-chip-sync sequencer.
//   - seq_state_e : sequencer FSM states
//   - cnt_width() : width of the shared duration down-counter
//   - parameter range limits checked at elaboration by the top level
package rfic_seq_pkg;

  localparam int RFIC_MIN        = 1;
  localparam int RFIC_MAX        = 8;
  localparam int SYNC_PULSES_MIN = 1;
  localparam int SYNC_PULSES_MAX = 15;
  localparam int PULSE_CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_ASSERT = 3'd1,
    ST_RST_WAIT   = 3'd2,
    ST_SYNC_HI    = 3'd3,
    ST_SYNC_LO    = 3'd4,
    ST_DONE       = 3'd5
  } seq_state_e;

  // One counter serves every timed state, so it must hold the largest duration.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rfic_status_sync.sv
// One device's CTRL_OUT status path: two-flop synchroniser plus sticky
// change flag.
//   clk, rst        : clock, synchronous active-high reset
//   status_in       : asynchronous CTRL_OUT bus of one device
//   clr_changed     : clears the sticky flag (a simultaneous new change wins)
//   status_sync     : synchronised status (second flop)
//   status_changed  : sticky flag, set whenever status_sync takes a new value
module rfic_status_sync
  import rfic_seq_pkg::*;
#(
  parameter int CTRL_OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_OUT_W-1:0] status_in,
  input  logic                  clr_changed,
  output logic [CTRL_OUT_W-1:0] status_sync,
  output logic                  status_changed
);

  logic [CTRL_OUT_W-1:0] meta_q, meta_d;
  logic [CTRL_OUT_W-1:0] sync_q, sync_d;
  logic                  changed_q, changed_d;

  always_comb begin
    meta_d = status_in;
    sync_d = meta_q;
    // meta_q != sync_q means status_sync changes on this edge, so the flag
    // rises in the same cycle as the new synchronised value appears.
    changed_d = (changed_q & ~clr_changed) | (meta_q != sync_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      changed_q <= changed_d;
    end
  end

  assign status_sync    = sync_q;
  assign status_changed = changed_q;

endmodule

// File: rtl/rfic_mcs_sequencer.sv
// Reset and multi-chip-sync sequencer for a group of AD9361-class RFICs.
// A full sequence pulses the masked resetb lines low, waits for the devices
// to settle, then issues NUM_SYNC_PULSES mcs_sync strobes. A sync-only
// sequence issues just the strobes. CTRL_OUT status buses are synchronised
// and change-flagged independently of the sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   cmd_start       : start full reset+sync sequence (wins over cmd_sync_only)
//   cmd_sync_only   : start sync-only sequence
//   rfic_mask       : devices included in the reset phase, sampled with command
//   gpio_status_in  : asynchronous CTRL_OUT buses, device k at [k*W +: W]
//   clr_changed     : per-device clear of status_changed
//   rfic_resetb     : active-low device resets (registered)
//   mcs_sync        : shared sync strobe (registered)
//   status_sync     : synchronised CTRL_OUT buses
//   status_changed  : sticky per-device change flags
//   busy            : sequence in progress
//   done            : one-cycle pulse at sequence completion
module rfic_mcs_sequencer
  import rfic_seq_pkg::*;
#(
  parameter int NUM_RFIC        = 2,
  parameter int CTRL_OUT_W      = 8,
  parameter int RESET_HOLD      = 1000,
  parameter int POST_RESET_WAIT = 20000,
  parameter int SYNC_PULSE_W    = 4,
  parameter int SYNC_GAP        = 64,
  parameter int NUM_SYNC_PULSES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_start,
  input  logic                           cmd_sync_only,
  input  logic [NUM_RFIC-1:0]            rfic_mask,
  input  logic [NUM_RFIC*CTRL_OUT_W-1:0] gpio_status_in,
  input  logic [NUM_RFIC-1:0]            clr_changed,
  output logic [NUM_RFIC-1:0]            rfic_resetb,
  output logic                           mcs_sync,
  output logic [NUM_RFIC*CTRL_OUT_W-1:0] status_sync,
  output logic [NUM_RFIC-1:0]            status_changed,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W = cnt_width(RESET_HOLD, POST_RESET_WAIT, SYNC_PULSE_W, SYNC_GAP);

  localparam logic [CNT_W-1:0]       LD_HOLD  = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]       LD_WAIT  = CNT_W'(POST_RESET_WAIT - 1);
  localparam logic [CNT_W-1:0]       LD_PULSE = CNT_W'(SYNC_PULSE_W - 1);
  localparam logic [CNT_W-1:0]       LD_GAP   = CNT_W'(SYNC_GAP - 1);
  localparam logic [PULSE_CNT_W-1:0] LD_NPUL  = PULSE_CNT_W'(NUM_SYNC_PULSES - 1);

  if (NUM_RFIC < RFIC_MIN || NUM_RFIC > RFIC_MAX ||
      NUM_SYNC_PULSES < SYNC_PULSES_MIN || NUM_SYNC_PULSES > SYNC_PULSES_MAX ||
      RESET_HOLD < 1 || POST_RESET_WAIT < 1 || SYNC_PULSE_W < 1 || SYNC_GAP < 1) begin : g_bad_params
    $error("rfic_mcs_sequencer: parameter out of range");
  end

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PULSE_CNT_W-1:0] pulse_q, pulse_d;
  logic [NUM_RFIC-1:0]    mask_q, mask_d;
  logic [NUM_RFIC-1:0]    resetb_q, resetb_d;
  logic                   mcs_sync_q, mcs_sync_d;

  // Counter holds "cycles remaining minus one" in the current state; it is
  // reloaded on every state entry and the state exits when it reads zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    pulse_d  = pulse_q;
    mask_d   = mask_q;
    resetb_d = resetb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d  = ST_RST_ASSERT;
          cnt_d    = LD_HOLD;
          mask_d   = rfic_mask;
          // Only masked devices go into reset; the rest keep their level.
          resetb_d = resetb_q & ~rfic_mask;
        end else if (cmd_sync_only) begin
          state_d = ST_SYNC_HI;
          cnt_d   = LD_PULSE;
          pulse_d = LD_NPUL;
          mask_d  = rfic_mask;
        end
      end
      ST_RST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d  = ST_RST_WAIT;
          cnt_d    = LD_WAIT;
          resetb_d = resetb_q | mask_q;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SYNC_HI;
          cnt_d   = LD_PULSE;
          pulse_d = LD_NPUL;
        end
      end
      ST_SYNC_HI: begin
        if (cnt_q == '0) begin
          // pulse_q counts the pulses still to follow this one.
          if (pulse_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SYNC_LO;
            cnt_d   = LD_GAP;
          end
        end
      end
      ST_SYNC_LO: begin
        if (cnt_q == '0) begin
          state_d = ST_SYNC_HI;
          cnt_d   = LD_PULSE;
          pulse_d = pulse_q - PULSE_CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so the strobe leaves a flop cleanly.
    mcs_sync_d = (state_d == ST_SYNC_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= '0;
      mask_q     <= '0;
      resetb_q   <= '0;
      mcs_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      mask_q     <= mask_d;
      resetb_q   <= resetb_d;
      mcs_sync_q <= mcs_sync_d;
    end
  end

  assign rfic_resetb = resetb_q;
  assign mcs_sync    = mcs_sync_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  for (genvar k = 0; k < NUM_RFIC; k++) begin : g_status
    rfic_status_sync #(
      .CTRL_OUT_W(CTRL_OUT_W)
    ) u_status_sync (
      .clk           (clk),
      .rst           (rst),
      .status_in     (gpio_status_in[k*CTRL_OUT_W +: CTRL_OUT_W]),
      .clr_changed   (clr_changed[k]),
      .status_sync   (status_sync[k*CTRL_OUT_W +: CTRL_OUT_W]),
      .status_changed(status_changed[k])
    );
  end

endmodule

// File: tb/tb_rfic_mcs_sequencer.sv
// Randomised bench for rfic_mcs_sequencer with a timeline-based reference
// model: each accepted command is turned into absolute cycle windows for
// resetb, mcs_sync, busy and done; status is modelled from input history.
module tb_rfic_mcs_sequencer;

  localparam int NR   = 2;
  localparam int CW   = 8;
  localparam int RH   = 8;
  localparam int PRW  = 4;
  localparam int PW   = 2;
  localparam int GAP  = 3;
  localparam int NP   = 3;
  localparam int NCYC = 3000;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_start;
  logic               cmd_sync_only;
  logic [NR-1:0]      rfic_mask;
  logic [NR*CW-1:0]   gpio_status_in;
  logic [NR-1:0]      clr_changed;
  logic [NR-1:0]      rfic_resetb;
  logic               mcs_sync;
  logic [NR*CW-1:0]   status_sync;
  logic [NR-1:0]      status_changed;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  rfic_mcs_sequencer #(
    .NUM_RFIC       (NR),
    .CTRL_OUT_W     (CW),
    .RESET_HOLD     (RH),
    .POST_RESET_WAIT(PRW),
    .SYNC_PULSE_W   (PW),
    .SYNC_GAP       (GAP),
    .NUM_SYNC_PULSES(NP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_start     (cmd_start),
    .cmd_sync_only (cmd_sync_only),
    .rfic_mask     (rfic_mask),
    .gpio_status_in(gpio_status_in),
    .clr_changed   (clr_changed),
    .rfic_resetb   (rfic_resetb),
    .mcs_sync      (mcs_sync),
    .status_sync   (status_sync),
    .status_changed(status_changed),
    .busy          (busy),
    .done          (done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Input history, indexed by the cycle in which the value was driven.
  logic             rst_h  [NCYC];
  logic [NR*CW-1:0] gpio_h [NCYC];
  logic [NR-1:0]    clr_h  [NCYC];

  function automatic logic [NR*CW-1:0] sync_at(input int n);
    if (n < 2) return '0;
    if (rst_h[n-1] || rst_h[n-2]) return '0;
    return gpio_h[n-2];
  endfunction

  // Sequence model state
  bit            active = 0;
  bit            seq_full;
  int            seq_c, seq_s, seq_end;
  logic [NR-1:0] seq_mask, seq_base;
  logic [NR-1:0] rb_idle = '0;
  logic [NR-1:0] chg_exp = '0;

  initial begin
    logic [NR-1:0]    e_rb, m, cl;
    logic             e_mcs, e_busy, e_done, r, cs, co;
    logic [NR*CW-1:0] s_now, s_prev, g;
    int               rel, p, pos;

    rst = 1'b1; cmd_start = 1'b0; cmd_sync_only = 1'b0;
    rfic_mask = '0; gpio_status_in = '0; clr_changed = '0;
    g = '0;
    e_busy = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      cyc = n;

      if (n >= 3) begin
        s_now  = sync_at(n);
        s_prev = sync_at(n - 1);
        if (rst_h[n-1]) begin
          active  = 0;
          rb_idle = '0;
          chg_exp = '0;
        end else begin
          chg_exp = chg_exp & ~clr_h[n-1];
          for (int k = 0; k < NR; k++)
            if (s_now[k*CW +: CW] != s_prev[k*CW +: CW]) chg_exp[k] = 1'b1;
        end

        if (active && n > seq_end) begin
          rb_idle = seq_full ? (seq_base | seq_mask) : seq_base;
          active  = 0;
        end

        e_rb = rb_idle; e_mcs = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (active) begin
          e_busy = 1'b1;
          e_done = (n == seq_end);
          if (seq_full)
            e_rb = (n <= seq_c + RH) ? (seq_base & ~seq_mask) : (seq_base | seq_mask);
          else
            e_rb = seq_base;
          if (n >= seq_s && n < seq_end) begin
            rel   = n - seq_s;
            p     = rel / (PW + GAP);
            pos   = rel % (PW + GAP);
            e_mcs = (p < NP) && (pos < PW);
          end
        end

        chk("rfic_resetb",    64'(rfic_resetb),    64'(e_rb));
        chk("mcs_sync",       64'(mcs_sync),       64'(e_mcs));
        chk("busy",           64'(busy),           64'(e_busy));
        chk("done",           64'(done),           64'(e_done));
        chk("status_sync",    64'(status_sync),    64'(s_now));
        chk("status_changed", 64'(status_changed), 64'(chg_exp));
      end

      // Stimulus for cycle n: a directed prologue, then random traffic.
      r = 1'b0; cs = 1'b0; co = 1'b0; cl = '0;
      m = NR'($urandom);
      if (n < 3) begin
        r = 1'b1;
      end else if (n < 200) begin
        case (n)
          5:   begin cs = 1'b1; m = 2'b11; end
          10:  cs = 1'b1;
          20:  co = 1'b1;
          40:  begin cs = 1'b1; m = 2'b01; end
          80:  co = 1'b1;
          120: begin cs = 1'b1; m = 2'b11; end
          130: r = 1'b1;
          150: g = {g[NR*CW-1:CW], 8'h5A};
          151: cl = 2'b01;
          160: begin cs = 1'b1; co = 1'b1; m = 2'b10; end
          default: ;
        endcase
      end else begin
        r  = ($urandom_range(0, 399) == 0);
        cs = ($urandom_range(0, 24) == 0);
        co = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 7) == 0) g = NR*CW'($urandom);
        if ($urandom_range(0, 3) == 0) cl = NR'($urandom);
      end

      rst_h[n]  = r;
      gpio_h[n] = g;
      clr_h[n]  = cl;

      rst            = r;
      cmd_start      = cs;
      cmd_sync_only  = co;
      rfic_mask      = m;
      gpio_status_in = g;
      clr_changed    = cl;

      // Command is taken only when the sequencer is idle this cycle and no
      // reset is arriving on the same edge.
      if (n >= 3 && !r && !e_busy && (cs || co)) begin
        active   = 1;
        seq_full = cs;
        seq_c    = n;
        seq_mask = m;
        seq_base = e_rb;
        seq_s    = cs ? (n + 1 + RH + PRW) : (n + 1);
        seq_end  = seq_s + NP * PW + (NP - 1) * GAP;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
